// File: rtl/seq_num_allocator.sv
// -----------------------------------------------------------------------------
// seq_num_allocator
//
// Purpose:
//   Issue-side sequence number allocator. It hands out in-order sequence
//   numbers to instructions entering execute and frees them again when the
//   writeback-commit unit broadcasts in-order commit notifications. It also
//   keeps a per-architectural-register pending-write scoreboard. An entry is
//   set when its writer is allocated. It is cleared by a complete
//   notification from that same writer.
//
// Ports:
//   clk              clock
//   rst              asynchronous active-low reset
//   alloc_val        decode requests a sequence number
//   alloc_rdy        a sequence number can be granted this cycle
//   alloc_waddr      destination register of the requesting instruction
//   alloc_wen        requesting instruction writes a register
//   alloc_seq_num    sequence number granted (valid while alloc_rdy)
//   complete_*       CompleteNotif broadcast (val, seq_num, waddr, wen)
//   commit_*         CommitNotif broadcast (val, seq_num)
//   rs1/rs2_addr     source register queries
//   rs1/rs2_busy     queried register has a pending write
//   num_inflight     allocated, not-yet-committed instruction count
//   commit_err       sticky flag for out-of-order or spurious commits
// -----------------------------------------------------------------------------
module seq_num_allocator #(
    parameter int p_seq_num_bits = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_val,
    output logic                      alloc_rdy,
    input  logic [4:0]                alloc_waddr,
    input  logic                      alloc_wen,
    output logic [p_seq_num_bits-1:0] alloc_seq_num,
    input  logic                      complete_val,
    input  logic [p_seq_num_bits-1:0] complete_seq_num,
    input  logic [4:0]                complete_waddr,
    input  logic                      complete_wen,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num,
    input  logic [4:0]                rs1_addr,
    input  logic [4:0]                rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [p_seq_num_bits:0]   num_inflight,
    output logic                      commit_err
);

    localparam logic [p_seq_num_bits-1:0] SEQ_ONE    = p_seq_num_bits'(1'b1);
    localparam logic [p_seq_num_bits-1:0] SEQ_ZERO   = p_seq_num_bits'(1'b0);
    localparam logic [p_seq_num_bits:0]   COUNT_ONE  = (p_seq_num_bits + 1)'(1'b1);
    localparam logic [p_seq_num_bits:0]   COUNT_ZERO = (p_seq_num_bits + 1)'(1'b0);
    // Full when count == 2^N, i.e. only the MSB of the count is set.
    localparam logic [p_seq_num_bits:0]   COUNT_FULL = {1'b1, SEQ_ZERO};

    logic [p_seq_num_bits-1:0] head_q, head_d;
    logic [p_seq_num_bits-1:0] tail_q, tail_d;
    logic [p_seq_num_bits:0]   count_q, count_d;
    logic [31:0]               busy_q, busy_d;
    logic [p_seq_num_bits-1:0] owner_q [32];
    logic [p_seq_num_bits-1:0] owner_d [32];
    logic                      commit_err_q, commit_err_d;

    logic fire_alloc_s;
    logic fire_commit_s;
    logic bad_commit_s;
    logic sb_set_s;
    logic sb_clr_s;

    // Handshake and commit legality, all derived from registered state only.
    always_comb begin
        alloc_rdy     = (count_q < COUNT_FULL);
        alloc_seq_num = head_q;
        fire_alloc_s  = alloc_val && alloc_rdy;
        fire_commit_s = commit_val && (count_q != COUNT_ZERO) && (commit_seq_num == tail_q);
        bad_commit_s  = commit_val && !fire_commit_s;
        sb_set_s      = fire_alloc_s && alloc_wen && (alloc_waddr != 5'd0);
        // Only the current owner may clear; a complete from an older writer is stale.
        sb_clr_s      = complete_val && complete_wen && (complete_waddr != 5'd0) &&
                        busy_q[complete_waddr] && (owner_q[complete_waddr] == complete_seq_num);
    end

    // Next-state for the head/tail pointers, in-flight count and error flag.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        commit_err_d = commit_err_q;
        if (fire_alloc_s) begin
            head_d = head_q + SEQ_ONE;
        end else begin
            head_d = head_q;
        end
        if (fire_commit_s) begin
            tail_d = tail_q + SEQ_ONE;
        end else begin
            tail_d = tail_q;
        end
        case ({fire_alloc_s, fire_commit_s})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
        if (bad_commit_s) begin
            commit_err_d = 1'b1;
        end else begin
            commit_err_d = commit_err_q;
        end
    end

    // Next-state for the scoreboard; the set is applied after the clear so it wins.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy_d[i]  = busy_q[i];
            owner_d[i] = owner_q[i];
            if (sb_clr_s && (complete_waddr == 5'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
            if (sb_set_s && (alloc_waddr == 5'(i))) begin
                busy_d[i]  = 1'b1;
                owner_d[i] = head_q;
            end else begin
                owner_d[i] = owner_q[i];
            end
        end
    end

    // State registers; reset discards all in-flight state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= SEQ_ZERO;
            tail_q       <= SEQ_ZERO;
            count_q      <= COUNT_ZERO;
            busy_q       <= 32'h0000_0000;
            commit_err_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                owner_q[i] <= SEQ_ZERO;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            commit_err_q <= commit_err_d;
            for (int i = 0; i < 32; i++) begin
                owner_q[i] <= owner_d[i];
            end
        end
    end

    // Source queries see registered busy only; x0 never reports a pending write.
    always_comb begin
        rs1_busy     = (rs1_addr != 5'd0) && busy_q[rs1_addr];
        rs2_busy     = (rs2_addr != 5'd0) && busy_q[rs2_addr];
        num_inflight = count_q;
        commit_err   = commit_err_q;
    end

endmodule

// File: tb/tb_seq_num_allocator.sv
module tb_seq_num_allocator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_val = 1'b0;
    logic       alloc_rdy;
    logic [4:0] alloc_waddr = 5'd0;
    logic       alloc_wen = 1'b0;
    logic [2:0] alloc_seq_num;
    logic       complete_val = 1'b0;
    logic [2:0] complete_seq_num = 3'd0;
    logic [4:0] complete_waddr = 5'd0;
    logic       complete_wen = 1'b0;
    logic       commit_val = 1'b0;
    logic [2:0] commit_seq_num = 3'd0;
    logic [4:0] rs1_addr = 5'd0;
    logic [4:0] rs2_addr = 5'd0;
    logic       rs1_busy;
    logic       rs2_busy;
    logic [3:0] num_inflight;
    logic       commit_err;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_q [$];

    seq_num_allocator #(.p_seq_num_bits(3)) dut (
        .clk(clk), .rst(rst),
        .alloc_val(alloc_val), .alloc_rdy(alloc_rdy),
        .alloc_waddr(alloc_waddr), .alloc_wen(alloc_wen),
        .alloc_seq_num(alloc_seq_num),
        .complete_val(complete_val), .complete_seq_num(complete_seq_num),
        .complete_waddr(complete_waddr), .complete_wen(complete_wen),
        .commit_val(commit_val), .commit_seq_num(commit_seq_num),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .num_inflight(num_inflight), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_val    = 1'b0;
        alloc_wen    = 1'b0;
        alloc_waddr  = 5'd0;
        complete_val = 1'b0;
        complete_wen = 1'b0;
        commit_val   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        step();
        exp_q.delete();
        chk("rst_rdy", 32'(alloc_rdy), 32'd1);
        chk("rst_seq", 32'(alloc_seq_num), 32'd0);
        chk("rst_inflight", 32'(num_inflight), 32'd0);
        chk("rst_err", 32'(commit_err), 32'd0);
    endtask

    // Grant check: the expected seq is queued when the request is driven and
    // popped when the DUT presents the grant.
    task automatic pop_grant(input string tag);
        logic [2:0] e;
        chk({tag, "_rdy"}, 32'(alloc_rdy), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_seq"}, 32'(alloc_seq_num), 32'(e));
        end
    endtask

    task automatic alloc_one(input logic [4:0] wa, input logic we, input logic [2:0] exp_seq);
        alloc_val   = 1'b1;
        alloc_waddr = wa;
        alloc_wen   = we;
        exp_q.push_back(exp_seq);
        pop_grant("alloc");
        step();
        alloc_val = 1'b0;
        alloc_wen = 1'b0;
    endtask

    task automatic complete_one(input logic [2:0] sn, input logic [4:0] wa);
        complete_val     = 1'b1;
        complete_wen     = 1'b1;
        complete_seq_num = sn;
        complete_waddr   = wa;
    endtask

    initial begin
        logic [2:0] tail_m;

        // Test 1: basic allocation and scoreboard query
        do_reset();
        alloc_one(5'd1, 1'b1, 3'd0);
        alloc_one(5'd2, 1'b1, 3'd1);
        alloc_one(5'd3, 1'b1, 3'd2);
        rs1_addr = 5'd2;
        rs2_addr = 5'd0;
        #1;
        chk("t1_inflight", 32'(num_inflight), 32'd3);
        chk("t1_rs1_busy", 32'(rs1_busy), 32'd1);
        chk("t1_rs2_x0", 32'(rs2_busy), 32'd0);
        rs2_addr = 5'd4;
        #1;
        chk("t1_rs2_idle", 32'(rs2_busy), 32'd0);

        // Test 2: fill, then commit while full does not bypass alloc_rdy
        do_reset();
        for (int i = 0; i < 8; i++) alloc_one(5'd0, 1'b0, 3'(i));
        chk("t2_full_rdy", 32'(alloc_rdy), 32'd0);
        chk("t2_full_inflight", 32'(num_inflight), 32'd8);
        alloc_val      = 1'b1;
        commit_val     = 1'b1;
        commit_seq_num = 3'd0;
        chk("t2_nobypass_rdy", 32'(alloc_rdy), 32'd0);
        step();
        commit_val = 1'b0;
        exp_q.push_back(3'd0);
        pop_grant("t2_regrant");
        chk("t2_after_commit", 32'(num_inflight), 32'd7);
        step();
        alloc_val = 1'b0;
        chk("t2_refull", 32'(num_inflight), 32'd8);
        chk("t2_err", 32'(commit_err), 32'd0);

        // Test 3: stale complete is ignored, owner's complete clears
        do_reset();
        alloc_one(5'd5, 1'b1, 3'd0);
        alloc_one(5'd5, 1'b1, 3'd1);
        rs1_addr = 5'd5;
        complete_one(3'd0, 5'd5);
        step();
        idle_inputs();
        chk("t3_stale", 32'(rs1_busy), 32'd1);
        complete_one(3'd1, 5'd5);
        #1;
        chk("t3_no_bypass", 32'(rs1_busy), 32'd1);
        step();
        idle_inputs();
        chk("t3_cleared", 32'(rs1_busy), 32'd0);

        // Test 4: set wins over same-cycle clear and takes ownership
        do_reset();
        alloc_one(5'd0, 1'b0, 3'd0);
        alloc_one(5'd7, 1'b1, 3'd1);
        rs2_addr = 5'd7;
        complete_one(3'd1, 5'd7);
        alloc_one(5'd7, 1'b1, 3'd2);
        idle_inputs();
        chk("t4_set_wins", 32'(rs2_busy), 32'd1);
        complete_one(3'd1, 5'd7);
        step();
        idle_inputs();
        chk("t4_old_owner", 32'(rs2_busy), 32'd1);
        complete_one(3'd2, 5'd7);
        step();
        idle_inputs();
        chk("t4_new_owner", 32'(rs2_busy), 32'd0);

        // Test 5: illegal commits set a sticky error without changing state
        do_reset();
        alloc_one(5'd0, 1'b0, 3'd0);
        alloc_one(5'd0, 1'b0, 3'd1);
        commit_val     = 1'b1;
        commit_seq_num = 3'd1;
        step();
        commit_val = 1'b0;
        chk("t5_ooo_err", 32'(commit_err), 32'd1);
        chk("t5_ooo_inflight", 32'(num_inflight), 32'd2);
        commit_val     = 1'b1;
        commit_seq_num = 3'd0;
        step();
        commit_seq_num = 3'd1;
        step();
        commit_val = 1'b0;
        chk("t5_drained", 32'(num_inflight), 32'd0);
        commit_val     = 1'b1;
        commit_seq_num = 3'd2;
        step();
        commit_val = 1'b0;
        chk("t5_empty_err", 32'(commit_err), 32'd1);
        chk("t5_empty_inflight", 32'(num_inflight), 32'd0);
        chk("t5_head_kept", 32'(alloc_seq_num), 32'd2);
        do_reset();

        // Test 6: back-to-back alloc + commit across the wrap point
        alloc_one(5'd0, 1'b0, 3'd0);
        tail_m = 3'd0;
        for (int i = 0; i < 20; i++) begin
            alloc_val      = 1'b1;
            commit_val     = 1'b1;
            commit_seq_num = tail_m;
            exp_q.push_back(3'(i + 1));
            pop_grant("t6_grant");
            step();
            tail_m = tail_m + 3'd1;
            chk("t6_inflight", 32'(num_inflight), 32'd1);
        end
        idle_inputs();
        chk("t6_err", 32'(commit_err), 32'd0);
        chk("t6_head", 32'(alloc_seq_num), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
